// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
// Imported by the top level and its testbench.
package spi_seq_pkg;

    localparam int LEN_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        XFER,
        GAP,
        HOLD
    } spi_seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO with show-ahead head data.
// A push is refused while full, even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];

    // Pointers are exactly AW bits wide, so plain increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset; only pointers and count need a known state.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Transaction front end for the byte-serial SPI master: sequences chip select,
// feeds TX bytes to the byte engine one at a time and collects RX bytes.
module spi_txn_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [7:0]       rx_data,
    output logic             byte_start,
    output logic [7:0]       byte_data,
    input  logic             byte_done,
    input  logic [7:0]       byte_rx,
    output logic             cs_n,
    output logic             busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    spi_seq_state_t   state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             byte_start_q, byte_start_d;
    logic [7:0]       byte_data_q, byte_data_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;

    logic             tx_full, tx_empty, tx_pop;
    logic [7:0]       tx_head;
    logic             rx_full, rx_empty, rx_push;
    logic             cmd_accept;
    logic             gap_done;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head_data (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (byte_rx),
        .pop       (rx_ready),
        .head_data (rx_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign cmd_ready  = (state_q == IDLE) && !rst;
    assign tx_ready   = !tx_full;
    assign rx_valid   = !rx_empty;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign gap_done   = (gap_cnt_q == GAP_LAST);

    assign byte_start = byte_start_q;
    assign byte_data  = byte_data_q;
    assign cs_n       = cs_n_q;
    assign busy       = busy_q;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        remaining_d  = remaining_q;
        byte_start_d = 1'b0;
        byte_data_d  = byte_data_q;
        tx_pop       = 1'b0;
        rx_push      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_accept && (cmd_len != '0)) begin
                    remaining_d = cmd_len;
                    state_d     = SETUP;
                end
            end
            SETUP, GAP: begin
                if (gap_done) begin
                    gap_cnt_d = '0;
                    state_d   = LOAD;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            LOAD: begin
                // Reserving an RX slot before starting makes RX overflow impossible.
                if (!tx_empty && !rx_full) begin
                    byte_start_d = 1'b1;
                    byte_data_d  = tx_head;
                    tx_pop       = 1'b1;
                    state_d      = XFER;
                end
            end
            XFER: begin
                if (byte_done) begin
                    rx_push     = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                    state_d     = (remaining_q == LEN_W'(1)) ? HOLD : GAP;
                end
            end
            HOLD: begin
                if (gap_done) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        // CS falls one cycle after leaving IDLE but rises together with the return to IDLE.
        cs_n_d = (state_q == IDLE) || (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            remaining_q  <= '0;
            byte_start_q <= 1'b0;
            byte_data_q  <= '0;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            remaining_q  <= remaining_d;
            byte_start_q <= byte_start_d;
            byte_data_q  <= byte_data_d;
            cs_n_q       <= cs_n_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Self-checking bench for spi_txn_sequencer: a byte-engine model, a negedge
// monitor with a queue-based transaction model, and one task per scenario.
module tb_spi_txn_sequencer;
    import spi_seq_pkg::*;

    localparam int DEPTH = 8;
    localparam int GAP   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [7:0]       rx_data;
    logic             byte_start;
    logic [7:0]       byte_data;
    logic             byte_done;
    logic [7:0]       byte_rx;
    logic             cs_n;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction model: bytes the host pushed, bytes the host must get back.
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] rx_xor = 8'h00;

    // Engine model knobs and state.
    int unsigned eng_lo = 0;
    int unsigned eng_hi = 4;
    bit          eng_busy = 0;
    bit          eng_stale = 0;
    logic [7:0]  eng_data = 8'h00;
    int unsigned eng_wait = 0;

    // Monitor statistics.
    int   cyc = 0;
    int   n_starts = 0;
    int   n_dones = 0;
    int   n_falls = 0;
    int   last_setup = 0;
    int   accept_cyc = -100;
    int   fall_cyc = 0;
    int   done_cyc = 0;
    int   txn_len = 0;
    int   txn_dones = 0;
    bit   pend_accept = 0;
    bit   first_start = 0;
    bit   inflight = 0;
    bit   cs_prev = 1;
    logic [7:0] inflight_tx = 8'h00;

    spi_txn_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .byte_start (byte_start),
        .byte_data  (byte_data),
        .byte_done  (byte_done),
        .byte_rx    (byte_rx),
        .cs_n       (cs_n),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte engine: answers each byte_start with one byte_done after a random latency.
    initial begin
        byte_done = 1'b0;
        byte_rx   = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            byte_done = 1'b0;
            if (eng_busy) begin
                if (rst) eng_stale = 1;
                if (!eng_stale) begin
                    n_checks++;
                    if (byte_data !== eng_data)
                        $display("FAIL byte_data_stable: got %02h, required %02h", byte_data, eng_data);
                    else
                        n_pass++;
                end
                if (eng_wait == 0) begin
                    byte_done = 1'b1;
                    byte_rx   = eng_data ^ rx_xor;
                    eng_busy  = 0;
                end else begin
                    eng_wait--;
                end
            end else if (byte_start === 1'b1 && !rst) begin
                eng_busy  = 1;
                eng_stale = 0;
                eng_data  = byte_data;
                eng_wait  = $urandom_range(eng_hi, eng_lo);
            end
        end
    end

    // Monitor: checks protocol timing and ordering against the transaction model.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            inflight    = 0;
            pend_accept = 0;
            cs_prev     = 1;
        end else begin
            if (cs_prev && !cs_n) begin
                n_falls++;
                n_checks++;
                if (!(pend_accept && cyc == accept_cyc + 2))
                    $display("FAIL cs_fall_timing: fell in cycle %0d, required cycle %0d", cyc, accept_cyc + 2);
                else
                    n_pass++;
                pend_accept = 0;
                fall_cyc    = cyc;
                txn_dones   = 0;
                first_start = 1;
            end
            if (!cs_prev && cs_n) begin
                n_checks++;
                if (cyc - done_cyc != GAP + 1)
                    $display("FAIL cs_hold: rose %0d cycles after last byte_done, required %0d", cyc - done_cyc, GAP + 1);
                else
                    n_pass++;
                n_checks++;
                if (cmd_ready !== 1'b1)
                    $display("FAIL cmd_ready_at_cs_rise: got %b, required 1", cmd_ready);
                else
                    n_pass++;
                n_checks++;
                if (txn_dones != txn_len)
                    $display("FAIL txn_byte_count: got %0d, required %0d", txn_dones, txn_len);
                else
                    n_pass++;
            end
            if (byte_start === 1'b1) begin
                n_starts++;
                n_checks++;
                if (cs_n !== 1'b0)
                    $display("FAIL cs_low_at_start: cs_n=%b, required 0", cs_n);
                else
                    n_pass++;
                n_checks++;
                if (exp_tx.size() == 0) begin
                    $display("FAIL byte_order: byte_start with data %02h but no byte expected", byte_data);
                    inflight_tx = byte_data;
                end else begin
                    inflight_tx = exp_tx.pop_front();
                    if (byte_data !== inflight_tx)
                        $display("FAIL byte_order: byte_data %02h, required %02h", byte_data, inflight_tx);
                    else
                        n_pass++;
                end
                n_checks++;
                if (first_start) begin
                    last_setup  = cyc - fall_cyc;
                    first_start = 0;
                    if (last_setup < GAP)
                        $display("FAIL cs_setup: %0d cycles, required at least %0d", last_setup, GAP);
                    else
                        n_pass++;
                end else begin
                    if (cyc - done_cyc < GAP + 1)
                        $display("FAIL inter_byte_gap: %0d cycles, required at least %0d", cyc - done_cyc, GAP + 1);
                    else
                        n_pass++;
                end
                inflight = 1;
            end
            if (byte_done === 1'b1 && inflight) begin
                n_dones++;
                txn_dones++;
                done_cyc = cyc;
                inflight = 0;
                exp_rx.push_back(inflight_tx ^ rx_xor);
            end
            if (cmd_valid && cmd_ready && cmd_len != '0) begin
                pend_accept = 1;
                accept_cyc  = cyc;
                txn_len     = int'(cmd_len);
            end
            cs_prev = cs_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        int t = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && t < 500) begin
            tick();
            t++;
        end
        if (tx_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL push_tx_timeout: tx_ready=%b, required 1", tx_ready);
        end
        tick();
        tx_valid = 1'b0;
        exp_tx.push_back(d);
    endtask

    task automatic issue_cmd(input int len);
        int t = 0;
        cmd_len = LEN_W'(len);
        while (cmd_ready !== 1'b1 && t < 500) begin
            tick();
            t++;
        end
        if (cmd_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL cmd_timeout: cmd_ready=%b, required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (!(busy === 1'b0 && cs_n === 1'b1) && t < budget) begin
            tick();
            t++;
        end
        if (!(busy === 1'b0 && cs_n === 1'b1)) begin
            n_checks++;
            $display("FAIL idle_timeout: busy=%b cs_n=%b, required 0/1", busy, cs_n);
        end
    endtask

    task automatic drain_rx(input int n);
        int got = 0;
        int t = 0;
        logic [7:0] exp;
        rx_ready = 1'b1;
        while (got < n && t < 1000) begin
            if (rx_valid === 1'b1) begin
                n_checks++;
                if (exp_rx.size() == 0) begin
                    $display("FAIL rx_data: got %02h with nothing expected", rx_data);
                end else begin
                    exp = exp_rx.pop_front();
                    if (rx_data !== exp)
                        $display("FAIL rx_data: got %02h, required %02h", rx_data, exp);
                    else
                        n_pass++;
                end
                got++;
            end
            tick();
            t++;
        end
        rx_ready = 1'b0;
        if (got < n) begin
            n_checks++;
            $display("FAIL rx_drain_timeout: got %0d bytes, required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++; if (cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b, required 1", cs_n); else n_pass++;
        n_checks++; if (byte_start !== 1'b0) $display("FAIL reset_byte_start: got %b, required 0", byte_start); else n_pass++;
        n_checks++; if (byte_data !== 8'h00) $display("FAIL reset_byte_data: got %02h, required 00", byte_data); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b, required 0", cmd_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b, required 0", rx_valid); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL post_reset_tx_ready: got %b, required 1", tx_ready); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL post_reset_cmd_ready: got %b, required 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_single_byte();
        int s0 = n_starts;
        rx_xor = 8'h99;
        push_tx(8'hA5);
        issue_cmd(1);
        wait_idle(200);
        n_checks++; if (n_starts - s0 != 1) $display("FAIL single_starts: got %0d, required 1", n_starts - s0); else n_pass++;
        n_checks++; if (last_setup != GAP) $display("FAIL single_setup: got %0d, required %0d", last_setup, GAP); else n_pass++;
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL single_rx_valid: got %b, required 1", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 8'h3C) $display("FAIL single_rx_data: got %02h, required 3c", rx_data); else n_pass++;
        drain_rx(1);
    endtask

    task automatic test_multi_byte();
        int s0 = n_starts;
        int f0 = n_falls;
        rx_xor = 8'h00;
        for (int i = 1; i <= 4; i++) push_tx(8'(i));
        issue_cmd(4);
        wait_idle(400);
        n_checks++; if (n_starts - s0 != 4) $display("FAIL multi_starts: got %0d, required 4", n_starts - s0); else n_pass++;
        n_checks++; if (n_falls - f0 != 1) $display("FAIL multi_cs_continuous: %0d cs falls, required 1", n_falls - f0); else n_pass++;
        drain_rx(4);
    endtask

    task automatic test_tx_underflow();
        int s0 = n_starts;
        rx_xor = 8'($urandom);
        push_tx(8'h11);
        issue_cmd(3);
        repeat (20) tick();
        n_checks++; if (cs_n !== 1'b0) $display("FAIL underflow_cs_n: got %b, required 0", cs_n); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL underflow_busy: got %b, required 1", busy); else n_pass++;
        n_checks++; if (n_starts - s0 != 1) $display("FAIL underflow_stall: %0d starts, required 1", n_starts - s0); else n_pass++;
        push_tx(8'h22);
        push_tx(8'h33);
        wait_idle(400);
        n_checks++; if (n_starts - s0 != 3) $display("FAIL underflow_starts: got %0d, required 3", n_starts - s0); else n_pass++;
        drain_rx(3);
    endtask

    task automatic test_rx_backpressure();
        int s0 = n_starts;
        int t = 0;
        rx_ready = 1'b0;
        rx_xor   = 8'($urandom);
        for (int i = 0; i < DEPTH; i++) push_tx(8'($urandom));
        issue_cmd(10);
        push_tx(8'($urandom));
        push_tx(8'($urandom));
        while (n_starts - s0 < DEPTH && t < 1000) begin
            tick();
            t++;
        end
        repeat (40) tick();
        n_checks++; if (n_starts - s0 != DEPTH) $display("FAIL bp_stall_starts: got %0d, required %0d", n_starts - s0, DEPTH); else n_pass++;
        n_checks++; if (cs_n !== 1'b0) $display("FAIL bp_cs_n: got %b, required 0", cs_n); else n_pass++;
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL bp_rx_valid: got %b, required 1", rx_valid); else n_pass++;
        drain_rx(10);
        wait_idle(400);
        n_checks++; if (n_starts - s0 != 10) $display("FAIL bp_total_starts: got %0d, required 10", n_starts - s0); else n_pass++;
        n_checks++; if (exp_rx.size() != 0) $display("FAIL bp_data_loss: %0d bytes outstanding, required 0", exp_rx.size()); else n_pass++;
    endtask

    task automatic test_zero_len();
        int s0 = n_starts;
        int f0 = n_falls;
        issue_cmd(0);
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL zero_cmd_ready: got %b, required 1", cmd_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b, required 0", busy); else n_pass++;
        repeat (10) tick();
        n_checks++; if (cs_n !== 1'b1) $display("FAIL zero_cs_n: got %b, required 1", cs_n); else n_pass++;
        n_checks++; if (n_falls - f0 != 0) $display("FAIL zero_cs_falls: got %0d, required 0", n_falls - f0); else n_pass++;
        n_checks++; if (n_starts - s0 != 0) $display("FAIL zero_starts: got %0d, required 0", n_starts - s0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int s0 = n_starts;
        int t = 0;
        rx_xor = 8'h00;
        eng_lo = 6;
        eng_hi = 6;
        for (int i = 0; i < 4; i++) push_tx(8'($urandom));
        issue_cmd(4);
        while (n_starts - s0 < 2 && t < 500) begin
            tick();
            t++;
        end
        n_checks++; if (n_starts - s0 != 2) $display("FAIL mid_reach_byte2: got %0d starts, required 2", n_starts - s0); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (cs_n !== 1'b1) $display("FAIL mid_cs_n_async: got %b, required 1", cs_n); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL mid_rx_flushed: got %b, required 0", rx_valid); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL mid_tx_ready: got %b, required 1", tx_ready); else n_pass++;
        exp_tx.delete();
        exp_rx.delete();
        repeat (2) tick();
        rst = 1'b0;
        eng_lo = 0;
        eng_hi = 4;
        repeat (12) tick();
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL mid_late_done_ignored: rx_valid=%b, required 0", rx_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b, required 0", busy); else n_pass++;
        s0 = n_starts;
        rx_xor = 8'h5A;
        push_tx(8'($urandom));
        issue_cmd(1);
        wait_idle(200);
        n_checks++; if (n_starts - s0 != 1) $display("FAIL mid_after_starts: got %0d, required 1", n_starts - s0); else n_pass++;
        drain_rx(1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int len = int'($urandom_range(DEPTH, 1));
            int s0  = n_starts;
            rx_xor = 8'($urandom);
            for (int i = 0; i < len; i++) push_tx(8'($urandom));
            issue_cmd(len);
            wait_idle(1000);
            n_checks++;
            if (n_starts - s0 != len)
                $display("FAIL random_starts: got %0d, required %0d", n_starts - s0, len);
            else
                n_pass++;
            drain_rx(len);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        rx_ready  = 1'b0;
        tick();
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_tx_underflow();
        test_rx_backpressure();
        test_zero_len();
        test_reset_mid();
        test_random();
        n_checks++;
        if (exp_tx.size() != 0 || exp_rx.size() != 0)
            $display("FAIL model_drained: tx=%0d rx=%0d outstanding, required 0/0", exp_tx.size(), exp_rx.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
